// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote, break detection and
// a first-word fall-through receive FIFO with RTS flow control.
module uart_rx_fifo #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_THRESH = FIFO_DEPTH - 2,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DIV_W-1:0]              divisor,
    input  logic                          rx_en,
    input  logic [1:0]                    data_bit_num,
    input  logic                          stop_bit_num,
    input  logic                          parity_en,
    input  logic                          parity_type,
    input  logic                          rx,
    input  logic                          rx_ready,
    input  logic                          overrun_clr,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic                          parity_error,
    output logic                          frame_error,
    output logic                          break_det,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          rts_n
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_t;

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    logic             r_sync1, r_sync2;

    assign w_tick = (r_div_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            if (w_tick)
                r_div_cnt <= (divisor > DIV_W'(1)) ? divisor - 1'b1 : '0;
            else
                r_div_cnt <= r_div_cnt - 1'b1;
        end
    end

    state_t      r_state;
    logic [SW-1:0] r_samp;
    logic        r_v0, r_v1;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_data;
    logic [1:0]  r_dbn;
    logic        r_sbn, r_pen, r_ptype;
    logic        r_pbit, r_ferr, r_stop_idx;
    logic        r_push;
    logic [10:0] r_push_word;
    logic        w_maj, w_vote, w_bit_end, w_last_data, w_perr, w_brk;

    assign w_maj       = (r_v0 & r_v1) | (r_v0 & r_sync2) | (r_v1 & r_sync2);
    assign w_vote      = w_tick && (r_samp == S_HI);
    assign w_bit_end   = w_tick && (r_samp == S_END);
    assign w_last_data = (r_bit_idx == {1'b1, r_dbn});
    assign w_perr      = r_pen & ((^r_data) ^ r_pbit ^ r_ptype);
    assign w_brk       = (r_data == 8'd0) && !(r_pen && r_pbit) && !w_maj;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_samp      <= '0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_bit_idx   <= '0;
            r_data      <= '0;
            r_dbn       <= '0;
            r_sbn       <= 1'b0;
            r_pen       <= 1'b0;
            r_ptype     <= 1'b0;
            r_pbit      <= 1'b0;
            r_ferr      <= 1'b0;
            r_stop_idx  <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_tick) begin
                r_samp <= w_bit_end ? '0 : r_samp + 1'b1;
                if (r_samp == S_LO)  r_v0 <= r_sync2;
                if (r_samp == S_MID) r_v1 <= r_sync2;
            end
            if (!rx_en) begin
                r_state <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: if (!r_sync2) begin
                        r_state    <= S_START;
                        r_samp     <= '0;
                        r_dbn      <= data_bit_num;
                        r_sbn      <= stop_bit_num;
                        r_pen      <= parity_en;
                        r_ptype    <= parity_type;
                        r_data     <= '0;
                        r_pbit     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                    end
                    S_START: begin
                        if (w_vote && w_maj)
                            r_state <= S_IDLE;
                        else if (w_bit_end)
                            r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (w_vote)
                            r_data[r_bit_idx] <= w_maj;
                        if (w_bit_end) begin
                            if (w_last_data)
                                r_state <= r_pen ? S_PARITY : S_STOP;
                            else
                                r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (w_vote)
                            r_pbit <= w_maj;
                        if (w_bit_end)
                            r_state <= S_STOP;
                    end
                    S_STOP: begin
                        // Frames end at the mid-bit vote so a back-to-back start edge is not missed
                        if (w_vote) begin
                            if (!r_stop_idx && w_brk) begin
                                r_push      <= 1'b1;
                                r_push_word <= {1'b1, 1'b1, w_perr, r_data};
                                r_state     <= S_BRK_WAIT;
                            end else if (r_stop_idx == r_sbn) begin
                                r_push      <= 1'b1;
                                r_push_word <= {1'b0, r_ferr | !w_maj, w_perr, r_data};
                                r_state     <= S_IDLE;
                            end else begin
                                r_ferr <= r_ferr | !w_maj;
                            end
                        end else if (w_bit_end) begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                    S_BRK_WAIT: if (r_sync2) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    logic [10:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          r_overrun, r_rts_n;
    logic          w_valid, w_full, w_pop, w_wr, w_ovf;
    logic [10:0]   w_head;

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == (AW + 1)'(FIFO_DEPTH));
    assign w_pop   = w_valid & rx_ready;
    assign w_wr    = r_push & (!w_full | w_pop);
    assign w_ovf   = r_push & w_full & !w_pop;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= r_push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
            r_rts_n   <= 1'b1;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
            if (w_ovf)
                r_overrun <= 1'b1;
            else if (overrun_clr)
                r_overrun <= 1'b0;
            r_rts_n <= (r_level >= (AW + 1)'(RTS_THRESH));
        end
    end

    assign rx_valid     = w_valid;
    assign rx_data      = w_valid ? w_head[7:0] : 8'd0;
    assign parity_error = w_valid & w_head[8];
    assign frame_error  = w_valid & w_head[9];
    assign break_det    = w_valid & w_head[10];
    assign overrun      = r_overrun;
    assign fifo_level   = r_level;
    assign rts_n        = r_rts_n;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected entries are queued at stimulus
// time and a negedge monitor compares every popped FIFO head.
module tb_uart_rx_fifo;
    localparam int BIT   = 64;
    localparam int DEPTH = 16;

    logic       clk, reset_n;
    logic [15:0] divisor;
    logic       rx_en, stop_bit_num, parity_en, parity_type, rx, rx_ready, overrun_clr;
    logic [1:0] data_bit_num;
    logic [7:0] rx_data;
    logic       rx_valid, parity_error, frame_error, break_det, overrun, rts_n;
    logic [4:0] fifo_level;

    typedef struct packed {
        logic       brk;
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_mode = 0;

    uart_rx_fifo dut (
        .clk(clk), .reset_n(reset_n), .divisor(divisor), .rx_en(rx_en),
        .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
        .parity_en(parity_en), .parity_type(parity_type), .rx(rx),
        .rx_ready(rx_ready), .overrun_clr(overrun_clr), .rx_data(rx_data),
        .rx_valid(rx_valid), .parity_error(parity_error),
        .frame_error(frame_error), .break_det(break_det), .overrun(overrun),
        .fifo_level(fifo_level), .rts_n(rts_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      rx_ready = 1'b0;
            else if (rdy_mode == 1) rx_ready = 1'b1;
            else                    rx_ready = 1'($urandom);
        end
    end

    always @(negedge clk) begin
        if (reset_n && rx_valid && rx_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected got d=%02h brk=%0d fe=%0d pe=%0d want none",
                         rx_data, break_det, frame_error, parity_error);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({break_det, frame_error, parity_error, rx_data} !== e) begin
                    n_err++;
                    $display("FAIL pop_entry got brk=%0d fe=%0d pe=%0d d=%02h want brk=%0d fe=%0d pe=%0d d=%02h",
                             break_det, frame_error, parity_error, rx_data, e.brk, e.fe, e.pe, e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] dbn, input logic sbn, input logic pen, input logic ptype);
        data_bit_num = dbn;
        stop_bit_num = sbn;
        parity_en    = pen;
        parity_type  = ptype;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] dbn, input logic sbn,
                              input logic pen, input logic ptype, input logic perr,
                              input logic serr, input bit expect_push);
        int         nb;
        logic [7:0] dm;
        logic       pbit;
        exp_t       e;
        nb   = int'(dbn) + 5;
        dm   = d & 8'((1 << nb) - 1);
        pbit = (^dm) ^ ptype ^ perr;
        e.d   = dm;
        e.pe  = pen & perr;
        e.fe  = serr;
        e.brk = 1'b0;
        if (expect_push) q.push_back(e);
        cfg(dbn, sbn, pen, ptype);
        tk(2);
        rx = 1'b0;
        tk(BIT);
        cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < nb; i++) begin
            rx = dm[i];
            tk(BIT);
        end
        if (pen) begin
            rx = pbit;
            tk(BIT);
        end
        rx = !serr;
        tk(BIT);
        if (sbn) begin
            rx = 1'b1;
            tk(BIT);
        end
        rx = 1'b1;
        tk(2 + $urandom_range(0, 30));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || rx_valid) && t < 4000) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_done", int'(t < 4000), 1);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] dbn;
        logic       sbn, pen, ptype, perr, serr;
        exp_t       e;
        int         lvl;

        reset_n = 1'b0;
        rx = 1'b1;
        rx_en = 1'b1;
        divisor = 16'd4;
        overrun_clr = 1'b0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        tk(3);
        @(negedge clk);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_flags", int'({break_det, frame_error, parity_error}), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_rts", int'(rts_n), 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rts_after_release", int'(rts_n), 0);

        rdy_mode = 0;
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("a5_level", int'(fifo_level), 1);
        chk("a5_valid", int'(rx_valid), 1);
        chk("a5_data", int'(rx_data), 'hA5);
        rdy_mode = 1;
        wait_drain();

        send_frame(8'h35, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain();

        rdy_mode = 0;
        tk(1);
        rx = 1'b0;
        tk(16);
        rx = 1'b1;
        tk(200);
        @(negedge clk);
        chk("glitch_level", int'(fifo_level), 0);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("after_glitch_level", int'(fifo_level), 1);
        rdy_mode = 1;
        wait_drain();

        rdy_mode = 0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        tk(2);
        rx = 1'b0;
        tk(BIT);
        rx = 1'b1;
        tk(BIT);
        rx = 1'b0;
        tk(32);
        rx_en = 1'b0;
        tk(3);
        rx = 1'b1;
        tk(200);
        rx_en = 1'b1;
        tk(200);
        @(negedge clk);
        chk("rxen_abort_level", int'(fifo_level), 0);

        e.brk = 1'b1;
        e.fe  = 1'b1;
        e.pe  = 1'b0;
        e.d   = 8'h00;
        q.push_back(e);
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        tk(2);
        rx = 1'b0;
        tk(20 * BIT);
        @(negedge clk);
        chk("break_level_low", int'(fifo_level), 1);
        chk("break_flag", int'(break_det), 1);
        tk(1);
        rx = 1'b1;
        tk(4 * BIT);
        @(negedge clk);
        chk("break_level_high", int'(fifo_level), 1);
        rdy_mode = 1;
        wait_drain();

        rdy_mode = 0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i <= DEPTH);
            lvl = (i < DEPTH) ? i : DEPTH;
            @(negedge clk);
            chk("ovf_level", int'(fifo_level), lvl);
            chk("ovf_rts", int'(rts_n), int'(lvl >= DEPTH - 2));
            chk("ovf_flag", int'(overrun), int'(i == DEPTH + 1));
        end
        rdy_mode = 1;
        wait_drain();
        chk("ovf_empty", int'(rx_valid), 0);
        chk("ovf_sticky", int'(overrun), 1);
        tk(1);
        overrun_clr = 1'b1;
        tk(1);
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", int'(overrun), 0);

        rdy_mode = 0;
        send_frame(8'h77, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        tk(2);
        rx = 1'b0;
        tk(BIT);
        rx = 1'b1;
        tk(BIT);
        rx = 1'b0;
        tk(BIT);
        rx = 1'b1;
        tk(20);
        reset_n = 1'b0;
        q.delete();
        #7;
        chk("mid_rst_valid", int'(rx_valid), 0);
        chk("mid_rst_data", int'(rx_data), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_rts", int'(rts_n), 1);
        tk(5);
        reset_n = 1'b1;
        tk(100);
        rdy_mode = 1;
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();

        rdy_mode = 2;
        for (int k = 0; k < 30; k++) begin
            d     = 8'($urandom);
            dbn   = 2'($urandom);
            sbn   = 1'($urandom);
            pen   = 1'($urandom);
            ptype = 1'($urandom);
            perr  = pen & ($urandom_range(0, 3) == 0);
            serr  = sbn & ($urandom_range(0, 3) == 0);
            if (serr) d[0] = 1'b1;
            send_frame(d, dbn, sbn, pen, ptype, perr, serr, 1'b1);
        end
        rdy_mode = 1;
        wait_drain();
        chk("final_level", int'(fifo_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter OVERSAMPLE, default 16: sample ticks per bit; SHALL be even and at least 8.
REQ-002 Parameter FIFO_DEPTH, default 16: receive FIFO entries; SHALL be a power of two and at least 2.
REQ-003 Parameter RTS_THRESH, default FIFO_DEPTH-2: fill level at which flow control stops the sender.
REQ-004 Parameter DIV_W, default 16: baud divisor width.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- divisor  in  DIV_W  clk cycles per sample tick.
- rx_en  in  1  receiver enable.
- data_bit_num  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- stop_bit_num  in  1  stop bits: 0=1, 1=2.
- parity_en  in  1  parity bit present.
- parity_type  in  1  parity: 0=even, 1=odd.
- rx  in  1  serial line, asynchronous.
- rx_ready  in  1  consumer accepts the FIFO head.
- overrun_clr  in  1  single-cycle pulse that clears overrun.
- rx_data  out  8  FIFO head data; unused high bits are 0.
- rx_valid  out  1  FIFO not empty.
- parity_error  out  1  head entry parity flag.
- frame_error  out  1  head entry framing flag.
- break_det  out  1  head entry break flag.
- overrun  out  1  sticky flag: a frame was dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- rts_n  out  1  active-low request-to-send.

Function
REQ-007 Tick generator: down-counter reloads with divisor-1 and emits a one-cycle tick when it reaches 0; divisor 0 or 1 SHALL give a tick every cycle.
REQ-008 rx SHALL pass through a 2-FF synchronizer (reset value 1) before any use.
REQ-009 FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-010 IDLE -> START on synchronized rx=0 while rx_en=1; the sample counter clears.
REQ-011 Config inputs SHALL be latched on the IDLE->START transition; changes mid-frame have no effect.
REQ-012 Bit value is the majority of samples OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
REQ-013 START: a majority value of 1 SHALL return the FSM to IDLE with no push (glitch reject); otherwise, at the end of the bit, go to DATA.
REQ-014 DATA: receive bits LSB first, 5-8 per the latched data_bit_num; after the last bit go to PARITY if parity_en, else STOP.
REQ-015 parity_error SHALL be set when the XOR of the data bits and the parity bit is 1 (even) or 0 (odd); it is 0 when parity is disabled.
REQ-016 STOP: each stop bit sampled 0 SHALL set frame_error.
- Push to the FIFO at the mid-bit vote of the last stop bit, then go directly to IDLE.
REQ-017 Break: data=0, parity bit (if enabled)=0 and first stop bit=0.
- Push with break_det=1 and frame_error=1, then go to BRK_WAIT.
- BRK_WAIT -> IDLE on synchronized rx=1.
REQ-018 rx_en=0 SHALL force IDLE within 1 cycle and abandon the in-progress frame with no push.
REQ-019 FIFO entry holds {break, frame, parity, data[7:0]}; first-word fall-through; outputs reflect the head combinationally from registers.
REQ-020 Pop occurs when rx_valid=1 and rx_ready=1; rx_ready while empty is ignored.
REQ-021 Push while full and no pop: frame discarded, overrun set, FIFO unchanged.
REQ-022 Push and pop in the same cycle while full: both occur, no overrun.
REQ-023 Push and pop in the same cycle while empty: push only; rx_valid=1 the next cycle.
REQ-024 overrun_clr clears overrun; if it coincides with a new overrun event, set wins.
REQ-025 rts_n is registered: 1 when fifo_level >= RTS_THRESH, else 0.
REQ-026 Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.

Reset
REQ-027 On reset_n=0, all of the following SHALL apply immediately:
- state=IDLE; synchronizer=1; counters=0.
- FIFO empty; rx_valid=0; rx_data=0; all error flags=0; overrun=0; fifo_level=0.
- rts_n=1, becoming 0 on the first clock after release.
REQ-028 Reset mid-frame SHALL discard the partial frame; the next start bit is received normally.

Verification (divisor=4, OVERSAMPLE=16, 64 clk/bit)
REQ-029 8N1 frame with 0xA5 -> rx_valid=1, rx_data=0xA5, all flags 0, fifo_level=1.
REQ-030 7E1 frame with 0x35 and parity bit driven 1 -> rx_data=0x35, parity_error=1.
REQ-031 rx low for 16 clk then high -> no push; FSM back in IDLE.
REQ-032 rx held low for 20 bit times, 8N1 -> one entry: rx_data=0x00, break_det=1, frame_error=1; no further push until rx high.
REQ-033 FIFO_DEPTH+1 frames (0x01..0x11), rx_ready=0 ->
- first 16 retained in order; overrun=1.
- rts_n=1 from level 14.
- draining pops all 16, then rx_valid=0.
REQ-034 reset_n pulsed low mid-DATA, then frame 0x3C -> outputs at reset values during reset, then rx_data=0x3C with no flags.
